// File: rtl/des_pkg.sv
// Shared widths, FSM encoding and job payload for the DES core arbiter.
package des_pkg;

  localparam int unsigned DES_BLOCK_W = 64;
  localparam int unsigned DES_RK_W    = 768;
  localparam int unsigned N_REQ       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [1:DES_BLOCK_W] message;
    logic [1:DES_RK_W]    round_keys;
  } des_job_t;

endpackage

// File: rtl/des_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, on contention the one not served last wins.
module des_rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[0] && valid[1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/des_core_arbiter.sv
// Shares one external DES core between two requesters: one job in flight,
// core watchdog, result held until the owning requester takes it.
module des_core_arbiter
  import des_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic [1:DES_BLOCK_W]  req_message_0,
  input  logic [1:DES_BLOCK_W]  req_message_1,
  input  logic [1:DES_RK_W]     req_round_keys_0,
  input  logic [1:DES_RK_W]     req_round_keys_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  input  logic                  rsp_ready_0,
  input  logic                  rsp_ready_1,
  output logic [1:DES_BLOCK_W]  rsp_result,
  output logic                  core_start,
  output logic [1:DES_BLOCK_W]  core_message,
  output logic [1:DES_RK_W]     core_round_keys,
  input  logic                  core_done,
  input  logic [1:DES_BLOCK_W]  core_result,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [1:0]       grant;
  logic             last_grant;
  logic             owner;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             accept;
  logic             rsp_ready_owner;
  des_job_t         job_sel;

  des_rr_arbiter2 u_rr (
    .valid      ({req_valid_1, req_valid_0}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign job_sel = grant[1] ? des_job_t'{message: req_message_1, round_keys: req_round_keys_1}
                            : des_job_t'{message: req_message_0, round_keys: req_round_keys_0};

  assign accept          = (state == ST_IDLE) && (|grant);
  assign tmo_hit         = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_ready_owner = owner ? rsp_ready_1 : rsp_ready_0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state; done on the last watchdog cycle still counts as completion
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          state_nxt = ST_RESP;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP:  if (rsp_ready_owner) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; ready is offered only in IDLE and only to the grantee
  always_comb begin
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    core_start  = 1'b0;
    rsp_valid_0 = 1'b0;
    rsp_valid_1 = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        busy        = 1'b0;
        req_ready_0 = grant[0];
        req_ready_1 = grant[1];
      end
      ST_ISSUE: core_start = 1'b1;
      ST_RESP: begin
        rsp_valid_0 = ~owner;
        rsp_valid_1 = owner;
      end
      default: ;
    endcase
  end

  // Operand, result, ownership and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_message    <= '0;
      core_round_keys <= '0;
      rsp_result      <= '0;
      owner           <= 1'b0;
      last_grant      <= 1'b1;
      tmo_cnt         <= '0;
      timeout_err     <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            core_message    <= job_sel.message;
            core_round_keys <= job_sel.round_keys;
            owner           <= grant[1];
            last_grant      <= grant[1];
          end
        end
        ST_ISSUE: tmo_cnt <= '0;
        ST_WAIT: begin
          if (core_done) begin
            rsp_result <= core_result;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_core_arbiter.sv
// Bench for des_core_arbiter: the bench plays both requesters and the DES core.
module tb_des_core_arbiter;
  import des_pkg::*;

  localparam int unsigned TMO = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req_valid_0, req_valid_1;
  logic                 req_ready_0, req_ready_1;
  logic [1:DES_BLOCK_W] req_message_0, req_message_1;
  logic [1:DES_RK_W]    req_round_keys_0, req_round_keys_1;
  logic                 rsp_valid_0, rsp_valid_1;
  logic                 rsp_ready_0, rsp_ready_1;
  logic [1:DES_BLOCK_W] rsp_result;
  logic                 core_start;
  logic [1:DES_BLOCK_W] core_message;
  logic [1:DES_RK_W]    core_round_keys;
  logic                 core_done;
  logic [1:DES_BLOCK_W] core_result;
  logic                 busy;
  logic                 timeout_err;

  des_core_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_0      (req_valid_0),
    .req_valid_1      (req_valid_1),
    .req_ready_0      (req_ready_0),
    .req_ready_1      (req_ready_1),
    .req_message_0    (req_message_0),
    .req_message_1    (req_message_1),
    .req_round_keys_0 (req_round_keys_0),
    .req_round_keys_1 (req_round_keys_1),
    .rsp_valid_0      (rsp_valid_0),
    .rsp_valid_1      (rsp_valid_1),
    .rsp_ready_0      (rsp_ready_0),
    .rsp_ready_1      (rsp_ready_1),
    .rsp_result       (rsp_result),
    .core_start       (core_start),
    .core_message     (core_message),
    .core_round_keys  (core_round_keys),
    .core_done        (core_done),
    .core_result      (core_result),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;

  // Reference state: who was served last and what result the requesters last saw
  int                   model_last = 1;
  logic [1:DES_BLOCK_W] model_result = '0;
  int                   served_q[$];

  bit                   use_force = 1'b0;
  logic [1:DES_BLOCK_W] force_msg;
  logic [1:DES_RK_W]    force_rk;

  always @(posedge clk) if (core_start) start_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One job from IDLE; lat=0 means the core never answers. Called and returns at a negedge.
  task automatic run_job(input bit v0, input bit v1, input int lat, input int bp,
                         input bit spurious, input logic [63:0] res);
    logic [1:DES_BLOCK_W] msg [2];
    logic [1:DES_RK_W]    rk  [2];
    int w;
    int s0;
    int nwait;
    for (int i = 0; i < 2; i++) begin
      msg[i] = {$urandom, $urandom};
      for (int k = 0; k < 24; k++) rk[i][32*k+1 +: 32] = $urandom;
    end
    if (use_force) begin
      msg[0] = force_msg;
      rk[0]  = force_rk;
    end
    req_message_0    = msg[0];
    req_message_1    = msg[1];
    req_round_keys_0 = rk[0];
    req_round_keys_1 = rk[1];
    req_valid_0      = v0;
    req_valid_1      = v1;
    w  = pick(v0, v1, model_last);
    s0 = start_cnt;
    #1;
    check("ready0_idle", 64'(req_ready_0), 64'(w == 0));
    check("ready1_idle", 64'(req_ready_1), 64'(w == 1));
    check("busy_idle", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    if (w == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
    model_last = w;
    served_q.push_back(w);
    check("core_start", 64'(core_start), 64'd1);
    check("busy_issue", 64'(busy), 64'd1);
    check("core_msg", 64'(core_message), 64'(msg[w]));
    check("core_rk", 64'(core_round_keys == rk[w]), 64'd1);
    check("ready_issue", 64'({req_ready_0, req_ready_1}), 64'd0);
    nwait = (lat == 0) ? int'(TMO) : lat;
    for (int c = 1; c <= nwait; c++) begin
      @(negedge clk);
      check("start_low", 64'(core_start), 64'd0);
      check("no_rsp_wait", 64'({rsp_valid_0, rsp_valid_1}), 64'd0);
      check("tmo_low", 64'(timeout_err), 64'd0);
      check("ready_wait", 64'({req_ready_0, req_ready_1}), 64'd0);
      check("msg_hold", 64'(core_message), 64'(msg[w]));
      check("rk_hold", 64'(core_round_keys == rk[w]), 64'd1);
      if (c == lat) begin
        core_done   = 1'b1;
        core_result = res;
      end
    end
    @(negedge clk);
    core_done = 1'b0;
    if (lat == 0) begin
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      check("tmo_pulse", 64'(timeout_err), 64'd1);
      check("busy_tmo", 64'(busy), 64'd0);
      check("no_rsp_tmo", 64'({rsp_valid_0, rsp_valid_1}), 64'd0);
      check("result_kept_tmo", 64'(rsp_result), 64'(model_result));
      @(negedge clk);
      check("tmo_one_cycle", 64'(timeout_err), 64'd0);
    end else begin
      model_result = res;
      check("rsp_valid_own", 64'(w == 0 ? rsp_valid_0 : rsp_valid_1), 64'd1);
      check("rsp_valid_other", 64'(w == 0 ? rsp_valid_1 : rsp_valid_0), 64'd0);
      check("rsp_result", 64'(rsp_result), 64'(model_result));
      check("busy_resp", 64'(busy), 64'd1);
      for (int b = 0; b < bp; b++) begin
        if (spurious && b == 0) begin
          core_done   = 1'b1;
          core_result = ~res;
        end
        @(negedge clk);
        core_done = 1'b0;
        check("bp_valid", 64'(w == 0 ? rsp_valid_0 : rsp_valid_1), 64'd1);
        check("bp_other", 64'(w == 0 ? rsp_valid_1 : rsp_valid_0), 64'd0);
        check("bp_result", 64'(rsp_result), 64'(model_result));
        check("bp_ready", 64'({req_ready_0, req_ready_1}), 64'd0);
      end
      if (w == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
      @(negedge clk);
      rsp_ready_0 = 1'b0;
      rsp_ready_1 = 1'b0;
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      check("rsp_drop", 64'({rsp_valid_0, rsp_valid_1}), 64'd0);
      check("busy_back_idle", 64'(busy), 64'd0);
    end
    check("start_once", 64'(start_cnt - s0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int v0, v1, lat;
    rst_n            = 1'b0;
    req_valid_0      = 1'b0;
    req_valid_1      = 1'b0;
    req_message_0    = '0;
    req_message_1    = '0;
    req_round_keys_0 = '0;
    req_round_keys_1 = '0;
    rsp_ready_0      = 1'b0;
    rsp_ready_1      = 1'b0;
    core_done        = 1'b0;
    core_result      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(core_start), 64'd0);
    check("rst_rsp", 64'({rsp_valid_0, rsp_valid_1}), 64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);
    check("rst_msg", 64'(core_message), 64'd0);
    check("rst_rk", 64'(core_round_keys == '0), 64'd1);
    check("rst_tmo", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    // Contention from the first cycle after reset alternates 0,1,0,1
    for (int i = 0; i < 4; i++) run_job(1'b1, 1'b1, 2, 0, 1'b0, {$urandom, $urandom});
    for (int i = 0; i < 4; i++) check("alternation", 64'(served_q[i]), 64'(i % 2));

    // Known-answer job: key 133457799BBCDFF1, round keys K1 and K16 shown
    force_rk          = '0;
    force_rk[1:48]    = 48'h1B02EFFC7072;
    force_rk[721:768] = 48'hCB3D8B0E17F5;
    force_msg         = 64'h0123456789ABCDEF;
    use_force         = 1'b1;
    run_job(1'b1, 1'b0, 3, 0, 1'b0, 64'h85E813540F0AB405);
    use_force         = 1'b0;
    check("kat_result", 64'(rsp_result), 64'h85E813540F0AB405);

    // Backpressure on requester 1 for 10 cycles, spurious done inside RESP
    run_job(1'b1, 1'b1, 4, 10, 1'b1, {$urandom, $urandom});

    // Spurious done in IDLE
    core_done   = 1'b1;
    core_result = {$urandom, $urandom};
    @(negedge clk);
    core_done = 1'b0;
    check("spur_idle_busy", 64'(busy), 64'd0);
    check("spur_idle_rsp", 64'({rsp_valid_0, rsp_valid_1}), 64'd0);
    check("spur_idle_result", 64'(rsp_result), 64'(model_result));

    // Timeout, and done landing exactly on the last watchdog cycle
    run_job(1'b1, 1'b0, 0, 0, 1'b0, 64'd0);
    run_job(1'b0, 1'b1, int'(TMO), 1, 1'b0, {$urandom, $urandom});

    // Reset while waiting on the core, then a late done
    req_message_0    = {$urandom, $urandom};
    req_round_keys_0 = '1;
    req_valid_0      = 1'b1;
    @(negedge clk);
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    core_done   = 1'b1;
    core_result = {$urandom, $urandom};
    @(negedge clk);
    core_done    = 1'b0;
    model_last   = 1;
    model_result = '0;
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_rsp", 64'({rsp_valid_0, rsp_valid_1}), 64'd0);
    check("rw_result", 64'(rsp_result), 64'd0);
    check("rw_msg", 64'(core_message), 64'd0);
    check("rw_start", 64'(core_start), 64'd0);
    check("rw_tmo", 64'(timeout_err), 64'd0);
    run_job(1'b1, 1'b1, 1, 0, 1'b0, {$urandom, $urandom});

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      v0 = int'($urandom_range(0, 1));
      v1 = int'($urandom_range(0, 1));
      if (v0 == 0 && v1 == 0) v0 = 1;
      lat = int'($urandom_range(0, TMO));
      run_job(v0 != 0, v1 != 0, lat, int'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
